// File: rtl/dense_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module      : dense_classifier_if
//  Description : Bundles the dense classifier's image/start request, its
//                weight-memory read port and its result signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface dense_classifier_if #(
   parameter int IMG_SIZE = 256,
   parameter int CLASSES  = 10,
   parameter int ACC_W    = 32
);
   logic                                start;
   logic [IMG_SIZE-1:0][7:0]            image;
   logic [$clog2(IMG_SIZE)-1:0]         w_addr;
   logic                                w_en;
   logic [CLASSES*8-1:0]                w_data;
   logic                                busy;
   logic                                done;
   logic [$clog2(CLASSES)-1:0]          pred_class;
   logic signed [ACC_W-1:0]             max_score;

   // Controller / weight-memory side
   modport master (
      output start, image, w_data,
      input  w_addr, w_en, busy, done, pred_class, max_score
   );

   // Classifier side
   modport slave (
      input  start, image, w_data,
      output w_addr, w_en, busy, done, pred_class, max_score
   );
endinterface
`default_nettype wire

// File: rtl/dense_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : dense_classifier
//  Description : One fully-connected layer over a latched 8-bit image with
//                streamed signed weights, followed by a sequential argmax.
//  Revision    : 1.0  initial release
// ============================================================================
module dense_classifier #(
   parameter int IMG_SIZE = 256,
   parameter int CLASSES  = 10,
   parameter int ACC_W    = 32
) (
   input  wire logic        clk,
   input  wire logic        rst,
   dense_classifier_if.slave bus
);
   localparam int c_AW = $clog2(IMG_SIZE);
   localparam int c_CW = $clog2(CLASSES);
   localparam logic [c_AW-1:0] c_LAST_PIX = c_AW'(IMG_SIZE - 1);
   localparam logic [c_CW-1:0] c_LAST_CLS = c_CW'(CLASSES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCUM  = 3'd1,
      S_DRAIN  = 3'd2,
      S_ARGMAX = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [IMG_SIZE-1:0][7:0] r_image;
   logic [c_AW-1:0]          r_pix_cnt;
   logic [c_AW-1:0]          r_pix_k;      // address issued in the previous cycle
   logic                     r_acc_vld;    // w_data this cycle belongs to r_pix_k
   logic signed [ACC_W-1:0]  r_acc [CLASSES];
   logic [c_CW-1:0]          r_cls;
   logic signed [ACC_W-1:0]  r_best;
   logic [c_CW-1:0]          r_best_idx;
   logic [c_CW-1:0]          r_pred;
   logic signed [ACC_W-1:0]  r_max;

   logic [7:0]               w_pix;
   logic signed [16:0]       w_px_ext;
   logic signed [16:0]       w_prod [CLASSES];
   logic signed [ACC_W-1:0]  w_acc_sel;
   logic                     w_take;
   logic signed [ACC_W-1:0]  w_nbest;
   logic [c_CW-1:0]          w_nidx;
   logic                     w_accept;

   assign w_accept       = (r_state == S_IDLE) && bus.start;
   assign w_pix          = r_image[r_pix_k];
   assign w_px_ext       = $signed({9'd0, w_pix});
   assign w_acc_sel      = r_acc[r_cls];
   assign w_take         = (r_cls == '0) || (w_acc_sel > r_best);
   assign w_nbest        = w_take ? w_acc_sel : r_best;
   assign w_nidx         = w_take ? r_cls : r_best_idx;
   assign bus.pred_class = r_pred;
   assign bus.max_score  = r_max;

   // Per-class product of the pending pixel (unsigned) and its signed weight
   always_comb begin
      for (int c = 0; c < CLASSES; c++) begin
         w_prod[c] = w_px_ext * 17'($signed(bus.w_data[8*c +: 8]));
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and control outputs
   always_comb begin
      w_next     = r_state;
      bus.w_en   = 1'b0;
      bus.w_addr = '0;
      bus.busy   = (r_state != S_IDLE);
      bus.done   = 1'b0;
      case (r_state)
         S_IDLE:   if (bus.start) w_next = S_ACCUM;
         S_ACCUM: begin
            bus.w_en   = 1'b1;
            bus.w_addr = r_pix_cnt;
            if (r_pix_cnt == c_LAST_PIX) w_next = S_DRAIN;
         end
         S_DRAIN:  w_next = S_ARGMAX;
         S_ARGMAX: if (r_cls == c_LAST_CLS) w_next = S_DONE;
         S_DONE: begin
            bus.done = 1'b1;
            w_next   = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // Image snapshot taken only on the accept edge; upstream may move on afterwards
   always_ff @(posedge clk) begin
      if (w_accept) r_image <= bus.image;
   end

   // Counters, accumulators, argmax tracking and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_cnt  <= '0;
         r_pix_k    <= '0;
         r_acc_vld  <= 1'b0;
         r_cls      <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_pred     <= '0;
         r_max      <= '0;
         for (int c = 0; c < CLASSES; c++) r_acc[c] <= '0;
      end else begin
         r_acc_vld <= (r_state == S_ACCUM);
         r_pix_k   <= r_pix_cnt;
         if (w_accept) begin
            for (int c = 0; c < CLASSES; c++) r_acc[c] <= '0;
         end else if (r_acc_vld) begin
            for (int c = 0; c < CLASSES; c++) r_acc[c] <= r_acc[c] + ACC_W'(w_prod[c]);
         end
         case (r_state)
            S_IDLE:   r_pix_cnt <= '0;
            S_ACCUM:  r_pix_cnt <= (r_pix_cnt == c_LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
            S_DRAIN:  r_cls <= '0;
            S_ARGMAX: begin
               r_best     <= w_nbest;
               r_best_idx <= w_nidx;
               r_cls      <= (r_cls == c_LAST_CLS) ? '0 : r_cls + 1'b1;
               if (r_cls == c_LAST_CLS) begin
                  r_pred <= w_nidx;
                  r_max  <= w_nbest;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dense_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dense_classifier
//  Description : Directed self-checking bench for dense_classifier.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dense_classifier;
   localparam int IMG_SIZE = 256;
   localparam int CLASSES  = 10;
   localparam int ACC_W    = 32;
   localparam int LAT      = IMG_SIZE + CLASSES + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [CLASSES*8-1:0] wmem [IMG_SIZE];

   dense_classifier_if #(.IMG_SIZE(IMG_SIZE), .CLASSES(CLASSES), .ACC_W(ACC_W)) bus ();

   dense_classifier #(.IMG_SIZE(IMG_SIZE), .CLASSES(CLASSES), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Weight BRAM: one-cycle read latency
   always @(posedge clk) begin
      if (bus.w_en) bus.w_data <= wmem[bus.w_addr];
   end

   task automatic clear_w();
      for (int a = 0; a < IMG_SIZE; a++) wmem[a] = '0;
   endtask

   task automatic set_w(input int cls, input logic [7:0] v);
      for (int a = 0; a < IMG_SIZE; a++) wmem[a][8*cls +: 8] = v;
   endtask

   task automatic fill_img(input int mode, input logic [7:0] v);
      for (int i = 0; i < IMG_SIZE; i++) bus.image[i] = (mode == 0) ? v : 8'(i);
   endtask

   // Pulse start and follow the run until done (bounded)
   task automatic do_run(output int lat, output int en_cnt, output int addr_err);
      int n;
      lat = -1; en_cnt = 0; addr_err = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (n < 400) begin
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.w_en) begin
            if (bus.w_addr !== 8'(en_cnt)) addr_err++;
            en_cnt++;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; fill_img(0, 8'd0); clear_w();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.w_en} !== 3'b000)
         $display("FAIL reset_ctrl busy/done/w_en=%b expected 000", {bus.busy, bus.done, bus.w_en});
      else n_pass++;
      n_checks++;
      if (bus.w_addr !== 8'd0 || bus.pred_class !== 4'd0 || bus.max_score !== 32'sd0)
         $display("FAIL reset_out addr=%0d pred=%0d max=%0d expected 0/0/0",
                  bus.w_addr, bus.pred_class, bus.max_score);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_weights();
      int lat, en, ae;
      clear_w(); fill_img(1, 8'd0);
      do_run(lat, en, ae);
      n_checks++;
      if (lat !== LAT) $display("FAIL zero_latency got %0d expected %0d", lat, LAT);
      else n_pass++;
      n_checks++;
      if (bus.pred_class !== 4'd0 || bus.max_score !== 32'sd0)
         $display("FAIL zero_result pred=%0d max=%0d expected 0/0", bus.pred_class, bus.max_score);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL zero_after done=%b busy=%b expected 0/0", bus.done, bus.busy);
      else n_pass++;
   endtask

   task automatic test_class3();
      int lat, en, ae;
      clear_w(); set_w(3, 8'd1); fill_img(0, 8'd1);
      do_run(lat, en, ae);
      n_checks++;
      if (en !== 256 || ae !== 0)
         $display("FAIL c3_sweep w_en_cycles=%0d addr_errors=%0d expected 256/0", en, ae);
      else n_pass++;
      n_checks++;
      if (bus.pred_class !== 4'd3 || bus.max_score !== 32'sd256)
         $display("FAIL c3_result pred=%0d max=%0d expected 3/256", bus.pred_class, bus.max_score);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_negative();
      int lat, en, ae;
      clear_w();
      for (int c = 0; c < CLASSES; c++) set_w(c, 8'h80);
      fill_img(0, 8'd255);
      do_run(lat, en, ae);
      n_checks++;
      if (bus.pred_class !== 4'd0 || bus.max_score !== -32'sd8355840)
         $display("FAIL neg_result pred=%0d max=%0d expected 0/-8355840", bus.pred_class, bus.max_score);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_ramp();
      int lat, en, ae;
      clear_w(); set_w(7, 8'd2); set_w(2, 8'd1); fill_img(1, 8'd0);
      do_run(lat, en, ae);
      n_checks++;
      if (lat !== LAT) $display("FAIL ramp_latency got %0d expected %0d", lat, LAT);
      else n_pass++;
      n_checks++;
      if (bus.pred_class !== 4'd7 || bus.max_score !== 32'sd65280)
         $display("FAIL ramp_result pred=%0d max=%0d expected 7/65280", bus.pred_class, bus.max_score);
      else n_pass++;
      @(negedge clk);
      // Only class 2 active: its score must win alone
      set_w(7, 8'd0);
      do_run(lat, en, ae);
      n_checks++;
      if (bus.pred_class !== 4'd2 || bus.max_score !== 32'sd32640)
         $display("FAIL ramp_c2 pred=%0d max=%0d expected 2/32640", bus.pred_class, bus.max_score);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_restart_ignored();
      int ndone, first, n;
      logic [3:0] pred;
      logic signed [31:0] mx;
      clear_w(); set_w(3, 8'd1); fill_img(0, 8'd1);
      ndone = 0; first = -1; pred = '0; mx = '0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (n = 1; n < 600; n++) begin
         if (n == 5)  fill_img(0, 8'd2);
         if (n == 10) bus.start = 1'b1;
         if (n == 11) bus.start = 1'b0;
         if (first >= 0 && n == first + 1) bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            if (first < 0) begin
               first = n; pred = bus.pred_class; mx = bus.max_score;
               bus.start = 1'b1;
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (ndone !== 1 || first !== LAT)
         $display("FAIL restart_pulses count=%0d first_at=%0d expected 1/%0d", ndone, first, LAT);
      else n_pass++;
      n_checks++;
      if (pred !== 4'd3 || mx !== 32'sd256)
         $display("FAIL restart_latched pred=%0d max=%0d expected 3/256", pred, mx);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL restart_idle busy=%b expected 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int lat, en, ae;
      clear_w(); set_w(7, 8'd2); set_w(2, 8'd1); fill_img(1, 8'd0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.w_en} !== 3'b000 || bus.w_addr !== 8'd0)
         $display("FAIL abort_ctrl busy/done/w_en=%b addr=%0d expected 000/0",
                  {bus.busy, bus.done, bus.w_en}, bus.w_addr);
      else n_pass++;
      n_checks++;
      if (bus.pred_class !== 4'd0 || bus.max_score !== 32'sd0)
         $display("FAIL abort_out pred=%0d max=%0d expected 0/0", bus.pred_class, bus.max_score);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      do_run(lat, en, ae);
      n_checks++;
      if (lat !== LAT || bus.pred_class !== 4'd7 || bus.max_score !== 32'sd65280)
         $display("FAIL abort_rerun lat=%0d pred=%0d max=%0d expected %0d/7/65280",
                  lat, bus.pred_class, bus.max_score, LAT);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      @(negedge clk);
      test_reset();
      test_zero_weights();
      test_class3();
      test_negative();
      test_ramp();
      test_restart_ignored();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
